// File: rtl/memory_data_pipe.sv
// memory_data_pipe: the data memory behind the load/store stage.
//   One write port with byte enables and one fully pipelined read port with a
//   registered read latency of RD_LAT cycles. A read in the same cycle as a
//   write to the same address sees the written bytes merged over the stored
//   word. After reset a clear sequencer can zero every word.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   Mwrite        write request; Mdst_addr / Mdst / Mbe give address, data, byte enables
//   Mread         read request; Msrc1_addr is the read address
//   Msrc1         read data, valid when Msrc1_valid is high, held otherwise
//   Msrc1_valid   one-cycle strobe, RD_LAT clocks after the read was sampled
//   Mbusy         high while the clear sweep runs; requests are dropped then
//   Merr          one-cycle pulse after an accepted out-of-range request

// One byte lane: its own byte-wide array plus the read data pipeline.
module memory_data_pipe_lane #(
  parameter int IW    = 8,
  parameter int DEPTH = 256,
  parameter int LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [IW-1:0]  waddr,
  input  logic [7:0]     wdata,
  input  logic [LAT-1:0] vld,    // vld[0] = read accepted this cycle
  input  logic           rzero,  // read address out of range: return zero
  input  logic [IW-1:0]  raddr,
  output logic [7:0]     rdata
);
  logic [7:0]         mem [DEPTH];
  logic [LAT:1][7:0]  dat;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Each stage only loads when its valid is set, so the output holds the
  // last returned byte between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat <= '0;
    end else begin
      if (vld[0]) begin
        if (rzero)                     dat[1] <= '0;
        else if (we && waddr == raddr) dat[1] <= wdata;  // write-first bypass
        else                           dat[1] <= mem[raddr];
      end
      for (int s = 2; s <= LAT; s++)
        if (vld[s-1]) dat[s] <= dat[s-1];
    end
  end

  assign rdata = dat[LAT];
endmodule

module memory_data_pipe #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 21,
  parameter int DEPTH          = 1048576,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mwrite,
  input  logic [ADDR_W-1:0]     Mdst_addr,
  input  logic [DATA_W-1:0]     Mdst,
  input  logic [DATA_W/8-1:0]   Mbe,
  input  logic                  Mread,
  input  logic [ADDR_W-1:0]     Msrc1_addr,
  output logic [DATA_W-1:0]     Msrc1,
  output logic                  Msrc1_valid,
  output logic                  Mbusy,
  output logic                  Merr
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = DEPTH_L - (ADDR_W+1)'(1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  // Array-side write request, shared by all byte lanes.
  typedef struct packed {
    logic [NUM_LANES-1:0]      be;
    logic [IW-1:0]             addr;
    logic [NUM_LANES-1:0][7:0] data;
  } arr_wr_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_we;
  logic              ready, wr_in, rd_in, wr_acc, rd_acc;
  arr_wr_t           awr;
  logic [RD_LAT:1]   vld_q;
  logic [RD_LAT:0]   vld_pipe;
  logic [NUM_LANES-1:0][7:0] lane_rd;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        // Pointer parks on the last word instead of wrapping.
        if ({1'b0, ptr_q} == LAST_L) state_d = S_READY;
        else                         ptr_d   = ptr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign Mbusy = (state_q == S_CLEAR);
  assign ready = (state_q == S_READY);

  // ---------------- request acceptance ----------------
  assign wr_in  = ({1'b0, Mdst_addr}  < DEPTH_L);
  assign rd_in  = ({1'b0, Msrc1_addr} < DEPTH_L);
  assign wr_acc = ready & Mwrite;
  assign rd_acc = ready & Mread;

  always_comb begin
    awr.be   = '0;
    awr.addr = Mdst_addr[IW-1:0];
    awr.data = Mdst;
    if (clr_we) begin
      awr.be   = '1;
      awr.addr = ptr_q[IW-1:0];
      awr.data = '0;
    end else if (wr_acc && wr_in) begin
      awr.be   = Mbe;
    end
  end

  // A simultaneous bad read and bad write still give a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Merr <= 1'b0;
    else     Merr <= (wr_acc & ~wr_in) | (rd_acc & ~rd_in);
  end

  // ---------------- read valid pipeline ----------------
  assign vld_pipe = {vld_q, rd_acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;  // flushes in-flight reads
    else     vld_q <= vld_pipe[RD_LAT-1:0];
  end

  assign Msrc1_valid = vld_pipe[RD_LAT];

  // ---------------- byte lanes ----------------
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    memory_data_pipe_lane #(
      .IW    (IW),
      .DEPTH (DEPTH),
      .LAT   (RD_LAT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (awr.be[g]),
      .waddr (awr.addr),
      .wdata (awr.data[g]),
      .vld   (vld_pipe[RD_LAT-1:0]),
      .rzero (~rd_in),
      .raddr (Msrc1_addr[IW-1:0]),
      .rdata (lane_rd[g])
    );
  end

  assign Msrc1 = lane_rd;
endmodule
